// File: rtl/ca_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ca_pkg : shared types and constants for the cellular-automaton rule engine
// Revision: 1.0
// ---------------------------------------------------------------------------
package ca_pkg;

  localparam int RULE_W = 8;

  typedef enum logic [1:0] {
    CA_IDLE = 2'd0,
    CA_RUN  = 2'd1,
    CA_HOLD = 2'd2
  } ca_state_e;

endpackage : ca_pkg
`default_nettype wire

// File: rtl/ca_cell_next.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ca_cell_next : one elementary-CA cell, rule lookup on a 3-cell neighbourhood
// Revision: 1.0
// ---------------------------------------------------------------------------
module ca_cell_next
  import ca_pkg::*;
(
  input  logic [RULE_W-1:0] rule,
  input  logic [2:0]        nbhd,
  output logic              next_bit
);

  // nbhd is {left, centre, right}, so it directly selects the rule bit
  assign next_bit = rule[nbhd];

endmodule : ca_cell_next
`default_nettype wire

// File: rtl/ca_rule_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ca_rule_engine : iterates a Wolfram elementary-CA rule over WIDTH cells
// Revision: 1.0
// ---------------------------------------------------------------------------
module ca_rule_engine
  import ca_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int GEN_W    = 16,
  parameter int BOUNDARY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [RULE_W-1:0] cfg_rule,
  input  logic [WIDTH-1:0]  cfg_seed,
  input  logic [GEN_W-1:0]  cfg_steps,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_state,
  output logic [GEN_W-1:0]  gen_count,
  output logic              busy
);

  ca_state_e         state_q;
  ca_state_e         state_d;
  logic [RULE_W-1:0] rule_q;
  logic [GEN_W-1:0]  steps_q;
  logic [GEN_W-1:0]  gen_q;
  logic [GEN_W-1:0]  gen_inc;
  logic [WIDTH-1:0]  cells_q;
  logic [WIDTH-1:0]  cells_nxt;
  logic              pad_left;
  logic              pad_right;
  logic [WIDTH+1:0]  ext;
  logic              accept;
  logic              advance;

  // pad_left sits beyond the leftmost cell (c[WIDTH]), pad_right beyond c[0] (c[-1])
  generate
    if (BOUNDARY == 0) begin : g_ring
      assign pad_left  = cells_q[0];
      assign pad_right = cells_q[WIDTH-1];
    end else begin : g_zero
      assign pad_left  = 1'b0;
      assign pad_right = 1'b0;
    end
  endgenerate

  assign ext = {pad_left, cells_q, pad_right};

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      ca_cell_next u_cell (
        .rule     (rule_q),
        .nbhd     (ext[i+2:i]),
        .next_bit (cells_nxt[i])
      );
    end
  endgenerate

  assign gen_inc = gen_q + 1'b1;
  assign accept  = (state_q == CA_IDLE) && cfg_valid;
  assign advance = (state_q == CA_RUN) && !abort;

  always_comb begin
    state_d = state_q;
    case (state_q)
      CA_IDLE: if (cfg_valid) state_d = (cfg_steps != '0) ? CA_RUN : CA_HOLD;
      CA_RUN: begin
        if (abort)                   state_d = CA_IDLE;
        else if (gen_inc == steps_q) state_d = CA_HOLD;
      end
      CA_HOLD: if (out_ready) state_d = CA_IDLE;
      default: state_d = CA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CA_IDLE;
      rule_q  <= '0;
      steps_q <= '0;
      gen_q   <= '0;
      cells_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rule_q  <= cfg_rule;
        steps_q <= cfg_steps;
        cells_q <= cfg_seed;
        gen_q   <= '0;
      end else if (advance) begin
        cells_q <= cells_nxt;
        gen_q   <= gen_inc;
      end
    end
  end

  assign cfg_ready = (state_q == CA_IDLE);
  assign out_valid = (state_q == CA_HOLD);
  assign busy      = (state_q == CA_RUN);
  assign out_state = cells_q;
  assign gen_count = gen_q;

endmodule : ca_rule_engine
`default_nettype wire

// File: tb/tb_ca_rule_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ca_rule_engine : ring and zero-boundary engines driven in lockstep
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_ca_rule_engine;

  localparam int W = 8;
  localparam int G = 16;

  typedef struct {
    logic [W-1:0] st;
    logic [G-1:0] gc;
    int           lo;
    int           hi;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_valid;
  logic [7:0]   cfg_rule;
  logic [W-1:0] cfg_seed;
  logic [G-1:0] cfg_steps;
  logic         abort;
  logic         out_ready;
  logic [1:0]   cfg_ready;
  logic [1:0]   out_valid;
  logic [1:0]   busy;
  logic [W-1:0] out_state [2];
  logic [G-1:0] gen_count [2];

  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  exp_t         q0[$];
  exp_t         q1[$];
  exp_t         e_m;
  logic         seen [2];
  logic [W-1:0] held [2];

  ca_rule_engine #(.WIDTH(W), .GEN_W(G), .BOUNDARY(0)) dut_ring (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready[0]),
    .cfg_rule(cfg_rule), .cfg_seed(cfg_seed), .cfg_steps(cfg_steps), .abort(abort),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_state(out_state[0]),
    .gen_count(gen_count[0]), .busy(busy[0])
  );

  ca_rule_engine #(.WIDTH(W), .GEN_W(G), .BOUNDARY(1)) dut_zero (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready[1]),
    .cfg_rule(cfg_rule), .cfg_seed(cfg_seed), .cfg_steps(cfg_steps), .abort(abort),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_state(out_state[1]),
    .gen_count(gen_count[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // One generation from the textbook definition: the cell's new value is the
  // rule bit numbered by the binary pattern left*4 + centre*2 + right.
  function automatic logic [W-1:0] ca_step(input logic [7:0] r, input logic [W-1:0] c, input int bnd);
    logic [W-1:0] n;
    for (int i = 0; i < W; i++) begin
      int lv, cv, rv;
      cv = int'(c[i]);
      if (i == W - 1) lv = (bnd != 0) ? 0 : int'(c[0]);
      else            lv = int'(c[i+1]);
      if (i == 0)     rv = (bnd != 0) ? 0 : int'(c[W-1]);
      else            rv = int'(c[i-1]);
      n[i] = r[lv * 4 + cv * 2 + rv];
    end
    return n;
  endfunction

  function automatic logic [W-1:0] model(input logic [7:0] r, input logic [W-1:0] s, input int n, input int bnd);
    logic [W-1:0] c;
    c = s;
    for (int g = 0; g < n; g++) c = ca_step(r, c, bnd);
    return c;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n || !out_valid[k]) begin
        seen[k] = 1'b0;
      end else if (!seen[k]) begin
        seen[k] = 1'b1;
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid dut%0d: out_valid=1 with no result pending (cycle %0d)", k, cyc);
          held[k] = out_state[k];
        end else begin
          if (k == 0) e_m = q0.pop_front();
          else        e_m = q1.pop_front();
          chk($sformatf("result_state dut%0d", k), out_state[k], e_m.st);
          chk($sformatf("result_gen dut%0d", k), gen_count[k], e_m.gc);
          total++;
          if (cyc < e_m.lo || cyc > e_m.hi) begin
            bad++;
            $display("FAIL latency dut%0d: out_valid at cycle %0d, expected %0d..%0d", k, cyc, e_m.lo, e_m.hi);
          end
          held[k] = e_m.st;
        end
      end else begin
        chk($sformatf("hold_stable dut%0d", k), out_state[k], held[k]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s cfg_ready dut%0d", tag, k), cfg_ready[k], 1);
      chk($sformatf("%s out_valid dut%0d", tag, k), out_valid[k], 0);
      chk($sformatf("%s busy dut%0d", tag, k), busy[k], 0);
      chk($sformatf("%s out_state dut%0d", tag, k), out_state[k], 0);
      chk($sformatf("%s gen_count dut%0d", tag, k), gen_count[k], 0);
    end
  endtask

  task automatic accept(input logic [7:0] r, input logic [W-1:0] s, input logic [G-1:0] n,
                        input bit want_result, output int k);
    int guard = 0;
    k = cyc;
    while (!(cfg_ready[0] && cfg_ready[1])) begin
      tick(1);
      guard++;
      if (guard > 3000) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: cfg_ready=%b, expected 11", cfg_ready);
        return;
      end
    end
    cfg_valid = 1'b1;
    cfg_rule  = r;
    cfg_seed  = s;
    cfg_steps = n;
    tick(1);
    cfg_valid = 1'b0;
    k = cyc;
    if (want_result) begin
      // steps=0 may surface in the acceptance cycle or the one after it
      q0.push_back('{model(r, s, int'(n), 0), n, k + int'(n), (n == 0) ? k + 1 : k + int'(n)});
      q1.push_back('{model(r, s, int'(n), 1), n, k + int'(n), (n == 0) ? k + 1 : k + int'(n)});
    end
  endtask

  task automatic wait_valid();
    int guard = 0;
    while (!(out_valid[0] && out_valid[1])) begin
      tick(1);
      guard++;
      if (guard > 3000) begin
        total++;
        bad++;
        $display("FAIL valid_timeout: out_valid=%b, expected 11", out_valid);
        return;
      end
    end
  endtask

  task automatic take_result(input int delay);
    wait_valid();
    tick(delay);
    for (int k = 0; k < 2; k++) chk($sformatf("valid_held dut%0d", k), out_valid[k], 1);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ready_after_take dut%0d", k), cfg_ready[k], 1);
      chk($sformatf("valid_after_take dut%0d", k), out_valid[k], 0);
    end
  endtask

  task automatic abort_at(input logic [7:0] r, input logic [W-1:0] s, input logic [G-1:0] n, input int a);
    int k;
    accept(r, s, n, 1'b0, k);
    tick(a);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("abort cfg_ready dut%0d", d), cfg_ready[d], 1);
      chk($sformatf("abort busy dut%0d", d), busy[d], 0);
      chk($sformatf("abort gen_count dut%0d", d), gen_count[d], a);
      chk($sformatf("abort out_state dut%0d", d), out_state[d], model(r, s, a, d));
    end
    tick(3);
  endtask

  initial begin
    int k;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_rule  = '0;
    cfg_seed  = '0;
    cfg_steps = '0;
    abort     = 1'b0;
    out_ready = 1'b0;
    tick(2);
    check_reset("por");
    rst_n = 1'b1;
    tick(1);

    accept(8'h34, 8'h04, 16'd1, 1'b1, k);
    take_result(0);
    accept(8'h5A, 8'h01, 16'd1, 1'b1, k);
    take_result(1);
    accept(8'hF0, 8'h01, 16'd3, 1'b1, k);
    take_result(4);
    accept(8'hCC, 8'hA5, 16'd1000, 1'b1, k);
    take_result(0);
    accept(8'hCC, 8'h3C, 16'd0, 1'b1, k);
    take_result(2);

    abort_at(8'hF0, 8'h01, 16'd10, 4);
    abort_at(8'hF0, 8'h81, 16'd10, 9);

    // config offered while running must be ignored
    accept(8'h6E, 8'h13, 16'd6, 1'b1, k);
    cfg_valid = 1'b1;
    cfg_rule  = 8'h0F;
    cfg_seed  = 8'hFF;
    cfg_steps = 16'd1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      for (int d = 0; d < 2; d++) chk($sformatf("run_cfg_ready dut%0d", d), cfg_ready[d], 0);
    end
    cfg_valid = 1'b0;
    take_result(1);

    // out_ready pulsed while running has no effect
    accept(8'h1E, 8'h40, 16'd4, 1'b1, k);
    out_ready = 1'b1;
    tick(2);
    out_ready = 1'b0;
    take_result(0);

    accept(8'hF0, 8'h5A, 16'd20, 1'b0, k);
    tick(5);
    rst_n = 1'b0;
    #1;
    check_reset("rst_run");
    tick(1);
    rst_n = 1'b1;
    tick(1);

    accept(8'h96, 8'h21, 16'd2, 1'b1, k);
    wait_valid();
    tick(2);
    rst_n = 1'b0;
    #1;
    check_reset("rst_hold");
    tick(1);
    rst_n = 1'b1;
    tick(1);

    for (int it = 0; it < 24; it++) begin
      logic [7:0]   r;
      logic [W-1:0] s;
      int           n;
      r = 8'($urandom);
      s = W'($urandom);
      n = int'($urandom_range(0, 12));
      if (n > 0 && $urandom_range(0, 3) == 0) begin
        abort_at(r, s, G'(n), int'($urandom_range(0, n - 1)));
      end else begin
        accept(r, s, G'(n), 1'b1, k);
        take_result(int'($urandom_range(0, 3)));
      end
    end

    chk("ring_queue_drained", q0.size(), 0);
    chk("zero_queue_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_ca_rule_engine
`default_nettype wire
